imem_boot_loader: RTL

- Loads program words into the 32-entry instruction memory from an 8-bit valid/ready byte stream before the core runs.
- Sits directly upstream of instruction memory. It owns the memory write port during load and holds the core idle through `cpu_run` until a complete, checksum-verified image has been written.
- Stream format: one length byte N (words, 1..DEPTH), then N×4 data bytes (big-endian, word 0 first), then one checksum byte (XOR of all data bytes).

---
 rtl/imem_boot_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length-prefixed, XOR-checksummed byte stream and writes it into
// instruction memory, then releases the core only when the checksum matches.
module imem_boot_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_run,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

  localparam logic [7:0] DEPTH_B = DEPTH[7:0];

  state_t        state, state_d;
  logic [AW:0]   word_cnt;
  logic [AW-1:0] addr;
  logic [1:0]    byte_idx;
  logic [7:0]    csum;
  logic [31:0]   asm_word;
  logic          accept;
  logic          last_word;

  // in_ready is a register, so the handshake never depends combinationally on in_valid.
  assign accept    = in_valid && in_ready;
  assign last_word = ({1'b0, addr} == (word_cnt - 1'b1));

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    case (state)
      S_LEN:  if (accept) state_d = (in_data == 8'd0 || in_data > DEPTH_B) ? S_ERR : S_DATA;
      S_DATA: if (accept && byte_idx == 2'd3 && last_word) state_d = S_CSUM;
      S_CSUM: if (accept) state_d = (in_data == csum) ? S_RUN : S_ERR;
      default: ;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN;
      word_cnt   <= '0;
      addr       <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      asm_word   <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state    <= state_d;
      // Flags follow the next state so done/error rise together with in_ready falling.
      in_ready <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      cpu_run  <= (state_d == S_RUN);
      done     <= (state_d == S_RUN);
      error    <= (state_d == S_ERR);
      imem_we  <= 1'b0;

      if (accept) begin
        case (state)
          S_LEN: begin
            word_cnt <= (AW+1)'(in_data);
            addr     <= '0;
            byte_idx <= '0;
            csum     <= '0;
          end
          S_DATA: begin
            asm_word <= {asm_word[23:0], in_data};
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr;
              imem_wdata <= {asm_word[23:0], in_data};
              // Holding on the last word keeps a full-depth load from wrapping to 0.
              if (!last_word) addr <= addr + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
